// File: rtl/sram_boot_loader.sv
// Boot loader: streams a LEN/words/CSUM frame from a byte host into the SRAM,
// then hands the SRAM bus to the CPU and releases cpu_hold after a good checksum.
module sram_boot_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_din,
  input  logic              cpu_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_din,
  output logic              sram_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            r_state;
  logic [7:0]        r_len;
  logic [7:0]        r_idx;
  logic [7:0]        r_sum;
  logic [7:0]        r_hi;
  logic [TW-1:0]     r_tmo;
  logic              r_rx_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_din;
  logic              r_done;
  logic              r_err;
  logic              r_hold;
  logic              w_hs;
  logic              w_pass;

  assign w_hs   = rx_valid & r_rx_ready;
  assign w_pass = (r_state == S_DONE);

  // Loader FSM with registered handshake, write strobe and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len      <= 8'd0;
      r_idx      <= 8'd0;
      r_sum      <= 8'd0;
      r_hi       <= 8'd0;
      r_tmo      <= '0;
      r_rx_ready <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_din      <= 16'd0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_hold     <= 1'b1;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state    <= S_LEN;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_hold     <= 1'b1;
            r_idx      <= 8'd0;
            r_sum      <= 8'd0;
            r_tmo      <= '0;
            r_rx_ready <= 1'b1;
          end
        end
        S_LEN, S_HI, S_LO, S_CSUM: begin
          if (w_hs) begin
            r_tmo <= '0;
            case (r_state)
              S_LEN: begin
                r_len   <= rx_data;
                r_sum   <= rx_data;
                r_state <= (rx_data == 8'd0) ? S_CSUM : S_HI;
              end
              S_HI: begin
                r_hi    <= rx_data;
                r_sum   <= r_sum + rx_data;
                r_state <= S_LO;
              end
              S_LO: begin
                r_sum      <= r_sum + rx_data;
                r_state    <= S_WRITE;
                r_rx_ready <= 1'b0;
                r_we       <= 1'b1;
                r_addr     <= BASE_ADDR + ADDR_W'(r_idx);
                r_din      <= {r_hi, rx_data};
              end
              default: begin
                r_rx_ready <= 1'b0;
                if (rx_data == r_sum) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_hold  <= 1'b0;
                end else begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
                  r_hold  <= 1'b1;
                end
              end
            endcase
          end else if (r_tmo == TW'(TIMEOUT)) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_hold     <= 1'b1;
            r_rx_ready <= 1'b0;
            r_tmo      <= '0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_WRITE: begin
          r_idx      <= r_idx + 8'd1;
          r_state    <= ((r_idx + 8'd1) == r_len) ? S_CSUM : S_HI;
          r_rx_ready <= 1'b1;
          r_tmo      <= '0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_rx_ready <= 1'b0;
        end
      endcase
    end
  end

  // Once loaded, the CPU owns the SRAM bus directly
  assign sram_addr = w_pass ? cpu_addr : r_addr;
  assign sram_din  = w_pass ? cpu_din  : r_din;
  assign sram_we   = w_pass ? cpu_we   : r_we;
  assign rx_ready  = r_rx_ready;
  assign cpu_hold  = r_hold;
  assign done      = r_done;
  assign err       = r_err;

endmodule
